// File: rtl/glm_op_sequencer_if.sv
// Instruction channel into the GLM operator sequencer.
// The issuer drives the master side; the sequencer consumes the slave side.
interface glm_op_sequencer_if #(
    parameter int NUM_OPS = 4
);
    localparam int OPW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    logic              instr_valid;
    logic              instr_ready;
    logic [OPW-1:0]    instr_opcode;
    logic [4:0][31:0]  instr_regs;
    logic [15:0]       instr_repeat;
    logic [13:0]       instr_stride;

    modport master (
        output instr_valid, instr_opcode, instr_regs, instr_repeat, instr_stride,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_regs, instr_repeat, instr_stride,
        output instr_ready
    );
endinterface

// File: rtl/glm_op_sequencer.sv
// Issues one instruction to one of NUM_OPS operator engines, repeating it with a
// stride on regs[3][13:0], with a per-issue watchdog and sticky error flags.
module glm_op_sequencer #(
    parameter int NUM_OPS       = 4,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    glm_op_sequencer_if.slave        instr,
    output logic [NUM_OPS-1:0]       op_start,
    input  logic [NUM_OPS-1:0]       op_done,
    output logic [4:0][31:0]         op_regs,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
    output logic                     busy,
    output logic                     instr_done,
    output logic [31:0]              instr_count,
    output logic [1:0]               error
);
    localparam int OPW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                   state, state_next;
    logic [OPW-1:0]           opcode_q;
    logic [13:0]              stride_q;
    logic [15:0]              rep_max;
    logic [15:0]              rep_idx;
    logic [TIMEOUT_WIDTH-1:0] wd;
    logic [TIMEOUT_WIDTH-1:0] wd_inc;
    logic [NUM_OPS-1:0]       sel;
    logic                     done_hit;
    logic                     spurious;
    logic                     accept;
    logic                     advance;
    logic                     complete;
    logic                     timeout;

    assign sel      = NUM_OPS'(1) << opcode_q;
    assign done_hit = |(op_done & sel);
    // Any done from a non-active engine is flagged, whatever the state.
    assign spurious = |(op_done & ~sel);
    assign wd_inc   = wd + 1'b1;

    assign instr.instr_ready = (state == IDLE) && !reset;
    assign busy              = (state != IDLE);
    assign op_start          = (state == ISSUE) ? sel : '0;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        advance    = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (instr.instr_valid && instr.instr_ready) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (done_hit) begin
                    if (rep_idx == rep_max) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = ISSUE;
                    end
                end else if (timeout_limit != '0 && wd_inc >= timeout_limit) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q    <= '0;
            stride_q    <= '0;
            rep_max     <= '0;
            rep_idx     <= '0;
            wd          <= '0;
            op_regs     <= '0;
            instr_done  <= 1'b0;
            instr_count <= '0;
            error       <= '0;
        end else begin
            instr_done <= complete;
            if (accept) begin
                opcode_q <= instr.instr_opcode;
                op_regs  <= instr.instr_regs;
                stride_q <= instr.instr_stride;
                rep_max  <= (instr.instr_repeat == '0) ? 16'd0 : instr.instr_repeat - 16'd1;
                rep_idx  <= '0;
            end
            if (advance) begin
                rep_idx          <= rep_idx + 16'd1;
                op_regs[3][13:0] <= op_regs[3][13:0] + stride_q;
            end
            if (complete) instr_count <= instr_count + 32'd1;
            if (state == ISSUE)     wd <= '0;
            else if (state == WAIT) wd <= wd_inc;
            if (spurious) error[0] <= 1'b1;
            if (timeout)  error[1] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_glm_op_sequencer.sv
// Scoreboard bench for glm_op_sequencer: stimulus queues expected starts/completions,
// a negedge monitor pops and compares whenever the DUT pulses op_start or instr_done.
module tb_glm_op_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  op_start;
    logic [3:0]  op_done = '0;
    logic [4:0][31:0] op_regs;
    logic [23:0] timeout_limit = '0;
    logic        busy, instr_done;
    logic [31:0] instr_count;
    logic [1:0]  error;

    glm_op_sequencer_if #(.NUM_OPS(4)) ibus ();

    glm_op_sequencer #(.NUM_OPS(4), .TIMEOUT_WIDTH(24)) dut (
        .clk(clk), .reset(reset), .instr(ibus.slave),
        .op_start(op_start), .op_done(op_done), .op_regs(op_regs),
        .timeout_limit(timeout_limit), .busy(busy), .instr_done(instr_done),
        .instr_count(instr_count), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [31:0] r3;
        logic [31:0] r0;
    } start_t;

    start_t      exp_start[$];
    logic [31:0] exp_done[$];
    logic [31:0] seen_r3[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every start pulse and every completion pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (op_start != '0) begin
                if (exp_start.size() == 0) chk("unexpected_op_start", op_start, 0);
                else begin
                    start_t e;
                    logic [3:0] oh;
                    e  = exp_start.pop_front();
                    oh = 4'(1) << e.op;
                    chk("op_start_onehot", op_start, oh);
                    chk("op_regs3", op_regs[3], e.r3);
                    chk("op_regs0", op_regs[0], e.r0);
                    seen_r3.push_back(op_regs[3]);
                end
            end
            if (instr_done) begin
                if (exp_done.size() == 0) chk("unexpected_instr_done", 1, 0);
                else chk("instr_count_at_done", instr_count, exp_done.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_instr_ready", ibus.instr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_start", op_start, 0);
        chk("rst_op_regs_nz", |op_regs, 0);
        chk("rst_instr_done", instr_done, 0);
        chk("rst_instr_count", instr_count, 0);
        chk("rst_error", error, 0);
        exp_cnt = '0;
        reset = 1'b0;
        #1;
        chk("ready_after_reset", ibus.instr_ready, 1);
        @(negedge clk);
    endtask

    // Issue one instruction; ends at the negedge of the first ISSUE cycle.
    task automatic send(input int op, input logic [31:0] r0, input logic [31:0] r3,
                        input int rep, input logic [13:0] stride, input int n_exp, input bit exp_dn);
        bit ok = 0;
        for (int r = 0; r < n_exp; r++) begin
            start_t e;
            logic [13:0] lo;
            lo   = r3[13:0] + 14'(r * int'(stride));
            e.op = op;
            e.r3 = {r3[31:14], lo};
            e.r0 = r0;
            exp_start.push_back(e);
        end
        if (exp_dn) begin
            exp_cnt = exp_cnt + 1;
            exp_done.push_back(exp_cnt);
        end
        ibus.instr_valid  = 1'b1;
        ibus.instr_opcode = 2'(op);
        ibus.instr_regs[0] = r0;
        ibus.instr_regs[1] = 32'h1111_1111;
        ibus.instr_regs[2] = 32'h2222_2222;
        ibus.instr_regs[3] = r3;
        ibus.instr_regs[4] = 32'h4444_4444;
        ibus.instr_repeat = 16'(rep);
        ibus.instr_stride = stride;
        for (int i = 0; i < 50; i++) begin
            if (ibus.instr_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        ibus.instr_valid = 1'b0;
        chk("start_latency", op_start, 4'(1) << op);
        @(negedge clk);
    endtask

    task automatic wait_start(input int op);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (op_start[op]) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("wait_op_start_timeout", 0, 1);
    endtask

    task automatic pulse_done(input int op);
        @(negedge clk);
        op_done = 4'(1) << op;
        @(negedge clk);
        op_done = '0;
    endtask

    task automatic run_engine(input int op, input int n, input int delay);
        for (int r = 0; r < n; r++) begin
            wait_start(op);
            repeat (delay - 1) @(negedge clk);
            pulse_done(op);
        end
    endtask

    initial begin
        ibus.instr_valid  = 1'b0;
        ibus.instr_opcode = '0;
        ibus.instr_regs   = '0;
        ibus.instr_repeat = '0;
        ibus.instr_stride = '0;
        do_reset();

        // Single issue; done arrives at cycle 10 relative to accept.
        send(1, 32'h0004_0010, 32'h0000_0000, 1, 14'd0, 1, 1);
        chk("single_busy", busy, 1);
        run_engine(1, 1, 8);
        chk("single_ready", ibus.instr_ready, 1);
        chk("single_count", instr_count, 1);
        chk("single_busy_done", busy, 0);
        @(negedge clk);
        chk("single_done_pulse_width", instr_done, 0);

        // Repeat 3 with stride wrapping inside [13:0].
        seen_r3.delete();
        send(2, 32'hAAAA_0000, 32'h0000_3FFE, 3, 14'd4, 3, 1);
        run_engine(2, 3, 2);
        chk("stride_nstarts", seen_r3.size(), 3);
        if (seen_r3.size() == 3) begin
            chk("stride_r3_0", seen_r3[0], 32'h0000_3FFE);
            chk("stride_r3_1", seen_r3[1], 32'h0000_0002);
            chk("stride_r3_2", seen_r3[2], 32'h0000_0006);
        end
        chk("stride_count", instr_count, 2);

        // Upper bits of regs[3] survive the stride update.
        send(3, 32'hDEAD_0000, 32'hFFFF_C001, 2, 14'h3FFF, 2, 1);
        run_engine(3, 2, 1);

        // repeat=0 behaves as one issue.
        send(0, 32'h0000_00AA, 32'h0000_0100, 0, 14'd7, 1, 1);
        run_engine(0, 1, 2);
        repeat (3) @(negedge clk);
        chk("rep0_count", instr_count, 4);

        // Watchdog expiry after 20 WAIT cycles, remaining repeats aborted.
        timeout_limit = 24'd20;
        send(1, 32'h0000_0BAD, 32'h0, 2, 14'd1, 1, 0);
        repeat (20) @(negedge clk);
        chk("to_busy_cycle21", busy, 1);
        chk("to_err_early", error, 0);
        @(negedge clk);
        chk("to_busy_cycle22", busy, 0);
        chk("to_error", error, 2'b10);
        chk("to_count", instr_count, 4);
        send(1, 32'h0000_0600, 32'h0, 1, 14'd0, 1, 1);
        run_engine(1, 1, 3);
        chk("post_to_count", instr_count, 5);

        // Done coinciding with watchdog expiry completes the instruction.
        timeout_limit = 24'd5;
        send(2, 32'h0000_0505, 32'h0, 1, 14'd0, 1, 1);
        run_engine(2, 1, 5);
        chk("race_count", instr_count, 6);
        chk("race_error", error, 2'b10);
        timeout_limit = 24'd0;

        do_reset();
        // op_done during the ISSUE cycle is ignored without error.
        send(0, 32'h0000_0001, 32'h0, 1, 14'd0, 1, 1);
        op_done = 4'b0001;
        @(negedge clk);
        op_done = '0;
        repeat (2) @(negedge clk);
        chk("issue_done_busy", busy, 1);
        chk("issue_done_error", error, 0);
        pulse_done(0);
        chk("issue_done_count", instr_count, 1);

        // Spurious done from another engine sets error[0] but keeps waiting.
        send(0, 32'h0000_0002, 32'h0, 1, 14'd0, 1, 1);
        @(negedge clk);
        op_done = 4'b0100;
        @(negedge clk);
        op_done = '0;
        @(negedge clk);
        chk("spur_error", error, 2'b01);
        chk("spur_busy", busy, 1);
        pulse_done(0);
        chk("spur_count", instr_count, 2);
        chk("spur_error_sticky", error, 2'b01);

        // Reset during WAIT of repeat 2 of 5.
        do_reset();
        send(3, 32'h0000_0303, 32'h0000_0100, 5, 14'd1, 2, 0);
        wait_start(3);
        pulse_done(3);
        wait_start(3);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        do_reset();
        repeat (10) @(negedge clk);
        chk("mid_idle_busy", busy, 0);

        chk("exp_start_empty", exp_start.size(), 0);
        chk("exp_done_empty", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
